// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
// Optional macro UART_RX_PARITY_EN adds the PARITY state to the rx state enum.
package uart_pkg;

  // The serial line rests at this level between frames.
  localparam logic LINE_IDLE = 1'b1;

  // Default number of system clock cycles per UART bit.
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line.
// Both flops reset to the idle line level, so no false start bit is seen
// when reset is released.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronisation of rx into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits;
// otherwise parity_err is tied low and no parity logic is built.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic             rx_s;
  logic             rx_prev_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             ready_q;
  logic             ferr_q;
  logic             rx_fall;
  logic             tick_half;
  logic             tick_bit;
  logic [7:0]       shift_d;
`ifdef UART_RX_PARITY_EN
  logic             perr_q;
  logic             par_bad_q;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  // Edge detect and sample-point decodes; LSB arrives first, so shift right.
  always_comb begin
    rx_fall   = rx_prev_q & ~rx_s;
    tick_half = (clk_cnt_q == HALF_LAST);
    tick_bit  = (clk_cnt_q == BIT_LAST);
    shift_d   = {rx_s, shift_q[7:1]};
  end

  // Receive FSM: mid-bit sampling, frame checks and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      rx_prev_q <= LINE_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_prev_q <= rx_s;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          // A line held low (e.g. after a frame error) never looks like a new edge.
          if (rx_fall) begin
            state_q   <= RX_START;
            clk_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (tick_half) begin
            clk_cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_bit) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_d;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (tick_bit) begin
            clk_cnt_q <= '0;
            par_bad_q <= rx_s ^ (^shift_q);
            state_q   <= RX_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (tick_bit) begin
            clk_cnt_q <= '0;
            state_q   <= RX_IDLE;
            // A low stop bit outranks a parity mismatch.
            if (!rx_s) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized bench for uart_rx at 16 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Drive cycle of the start bit to pulse cycle: two synchronizer flops,
  // one cycle to register the edge, half a bit to the start sample, nine
  // (ten with parity) bit periods to the stop sample; the pulse is visible
  // in the cycle after the stop sample is registered.
  localparam int LAT   = 3 + CPB / 2 + (9 + PB) * CPB;
  localparam int FRAME = (10 + PB) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  logic       par_flip = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         rdy_cyc[$];
  logic [7:0] rdy_dat[$];
  int ferr_n = 0, perr_n = 0, ovl_n = 0, busy_n = 0;
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      rdy_cyc.push_back(cyc);
      rdy_dat.push_back(data_out);
    end
    if (frame_err === 1'b1)  ferr_n <= ferr_n + 1;
    if (parity_err === 1'b1) perr_n <= perr_n + 1;
    if ((int'(data_ready) + int'(frame_err) + int'(parity_err)) > 1) ovl_n <= ovl_n + 1;
    if (busy === 1'b1) busy_n <= busy_n + 1;
  end

  int r0, f0, p0, o0, b0;
  task automatic mark();
    r0 = rdy_dat.size();
    f0 = ferr_n;
    p0 = perr_n;
    o0 = ovl_n;
    b0 = busy_n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s;
    int         exp_cyc[$];
    logic [7:0] exp_dat[$];
    int         ferr_exp, perr_exp, gap;
    logic [7:0] d, last_good;
    logic       stop_b;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_ready", 32'(data_ready), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Single good frame
    mark();
    s = cyc;
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("a5_ready_cnt", 32'(rdy_dat.size() - r0), 32'd1);
    if (rdy_dat.size() > r0) begin
      check("a5_data",    32'(rdy_dat[r0]), 32'hA5);
      check("a5_latency", 32'(rdy_cyc[r0] - s), 32'(LAT));
    end
    check("a5_busy_after", 32'(busy), 32'h0);
    check("a5_ferr", 32'(ferr_n - f0), 32'd0);
    check("a5_perr", 32'(perr_n - p0), 32'd0);

    // Back-to-back frames, no idle gap
    mark();
    s = cyc;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("b2b_ready_cnt", 32'(rdy_dat.size() - r0), 32'd2);
    if (rdy_dat.size() >= r0 + 2) begin
      check("b2b_data0",   32'(rdy_dat[r0]),     32'hA5);
      check("b2b_data1",   32'(rdy_dat[r0 + 1]), 32'h3C);
      check("b2b_spacing", 32'(rdy_cyc[r0 + 1] - rdy_cyc[r0]), 32'(FRAME));
      check("b2b_latency", 32'(rdy_cyc[r0] - s), 32'(LAT));
    end
    check("b2b_errs", 32'((ferr_n - f0) + (perr_n - p0)), 32'd0);

    // Start-bit glitch of 3 cycles
    mark();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_pulses", 32'((rdy_dat.size() - r0) + (ferr_n - f0) + (perr_n - p0)), 32'd0);
    check("glitch_data",   32'(data_out), 32'h3C);
    check("glitch_busy_cycles", 32'(busy_n - b0), 32'(CPB / 2));
    check("glitch_busy_end", 32'(busy), 32'h0);

    // Stop bit low, then line held low
    mark();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    b0 = busy_n;
    repeat (3 * CPB) @(negedge clk);
    check("ferr_cnt",        32'(ferr_n - f0), 32'd1);
    check("ferr_no_ready",   32'(rdy_dat.size() - r0), 32'd0);
    check("ferr_no_perr",    32'(perr_n - p0), 32'd0);
    check("ferr_data_held",  32'(data_out), 32'h3C);
    check("ferr_low_idle",   32'(busy_n - b0), 32'd0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    mark();
    s = cyc;
    send_frame(8'h96, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("rearm_ready_cnt", 32'(rdy_dat.size() - r0), 32'd1);
    if (rdy_dat.size() > r0) begin
      check("rearm_data",    32'(rdy_dat[r0]), 32'h96);
      check("rearm_latency", 32'(rdy_cyc[r0] - s), 32'(LAT));
    end

    // Reset during bit 4 of a frame
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_outputs",  32'({data_ready, frame_err, parity_err, busy}), 32'h0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    s = cyc;
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("midrst_ready_cnt", 32'(rdy_dat.size() - r0), 32'd1);
    if (rdy_dat.size() > r0) begin
      check("midrst_data",    32'(rdy_dat[r0]), 32'h5A);
      check("midrst_latency", 32'(rdy_cyc[r0] - s), 32'(LAT));
    end
    check("midrst_errs", 32'((ferr_n - f0) + (perr_n - p0)), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Parity: wrong then correct parity bit
    mark();
    par_flip = 1'b1;
    send_frame(8'hA5, 1'b1);
    par_flip = 1'b0;
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("par_bad_perr",  32'(perr_n - p0), 32'd1);
    check("par_bad_ready", 32'(rdy_dat.size() - r0), 32'd0);
    check("par_bad_data",  32'(data_out), 32'h5A);
    mark();
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("par_ok_ready", 32'(rdy_dat.size() - r0), 32'd1);
    check("par_ok_data",  32'(data_out), 32'hA5);
    check("par_ok_perr",  32'(perr_n - p0), 32'd0);
`endif

    // Randomized frames against a frame-level reference model
    mark();
    last_good = data_out;
    ferr_exp = 0;
    perr_exp = 0;
    for (int n = 0; n < 24; n++) begin
      d        = 8'($urandom);
      stop_b   = ($urandom_range(0, 3) != 0);
      par_flip = ($urandom_range(0, 2) == 0);
      s = cyc;
      send_frame(d, stop_b);
      if (!stop_b) begin
        ferr_exp++;
      end else if (PB == 1 && par_flip) begin
        perr_exp++;
      end else begin
        exp_dat.push_back(d);
        exp_cyc.push_back(s + LAT);
        last_good = d;
      end
      // The line must go high again after a low stop bit before a new edge.
      if (!stop_b) gap = CPB + $urandom_range(0, CPB);
      else if ($urandom_range(0, 2) == 0) gap = 0;
      else gap = $urandom_range(1, 2 * CPB);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    par_flip = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("rand_ready_cnt", 32'(rdy_dat.size() - r0), 32'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (r0 + i < rdy_dat.size()) begin
        check("rand_data",  32'(rdy_dat[r0 + i]), 32'(exp_dat[i]));
        check("rand_cycle", 32'(rdy_cyc[r0 + i]), 32'(exp_cyc[i]));
      end
    end
    check("rand_ferr_cnt", 32'(ferr_n - f0), 32'(ferr_exp));
    check("rand_perr_cnt", 32'(perr_n - p0), 32'(perr_exp));
    check("rand_overlap",  32'(ovl_n - o0), 32'd0);
    check("rand_last_data", 32'(data_out), 32'(last_good));
    check("rand_busy_end", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: system clk cycles per UART bit; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame; fixed at 8 in this release.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  serial line (asynchronous); idles high.
REQ-006 data_out  output  8  last correctly received byte, held until the next good frame.
REQ-007 data_ready  output  1  one-cycle pulse; data_out is valid in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-010 busy  output  1  high in every state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; a single bit counter bit_cnt (0-7) and a tick counter clk_cnt (0 to CLKS_PER_BIT-1).
REQ-013 IDLE->START SHALL occur on a 1->0 transition of rx_s; clk_cnt is cleared.
  - After a frame error, rx held low SHALL NOT re-arm the receiver until rx_s has been high.
REQ-014 START SHALL sample rx_s when clk_cnt = CLKS_PER_BIT/2-1.
  - rx_s low: go to DATA, bit_cnt = 0.
  - rx_s high (glitch): return to IDLE, no output pulse.
REQ-015 DATA SHALL sample each bit every CLKS_PER_BIT cycles, LSB first, into a shift register.
  - After bit 7: go to PARITY if enabled, else STOP.
REQ-016 STOP SHALL sample rx_s one bit period after the last data/parity sample.
  - High and no parity error: load data_out and pulse data_ready.
  - Low: pulse frame_err; data_out is unchanged.
  - Both cases: return to IDLE.
REQ-017 Latency: with the synchronized falling edge in cycle t0, the stop sample SHALL be at cycle t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT (+CLKS_PER_BIT with parity). The output pulse is registered and appears in the following cycle.
REQ-018 data_ready, frame_err and parity_err SHALL each be high for exactly one cycle per frame and SHALL be mutually exclusive.
REQ-019 Back-to-back frames, with the next start bit directly after the stop bit, SHALL be received without loss. A falling edge detected in the cycle the FSM returns to IDLE SHALL be honoured.

Reset
REQ-020 With reset high at a clk edge, the block SHALL:
  - enter IDLE;
  - clear clk_cnt, bit_cnt and the shift register;
  - set data_out=8'h00, data_ready=0, frame_err=0, parity_err=0, busy=0;
  - set both synchronizer flops to 1.
REQ-021 Reset mid-frame SHALL abandon the frame with no output pulse; the first complete frame after reset deasserts SHALL be received correctly.

Configuration
REQ-022 Macro UART_RX_PARITY_EN defined:
  - PARITY state is compiled in; one even-parity bit follows bit 7.
  - On mismatch with stop high: parity_err pulses instead of data_ready, and data_out is unchanged.
  - Mismatch with stop low: frame_err has priority.
REQ-023 Macro undefined: no PARITY state or logic; parity_err SHALL be tied to 0.

Structure
REQ-024 Package uart_pkg SHALL hold:
  - the rx state enum;
  - the IDLE line level constant;
  - the default CLKS_PER_BIT.
  The existing transmitter SHALL reuse the same package.
REQ-025 Sub-module uart_rx_sync (2-flop synchronizer with reset value 1) SHALL be instantiated once; everything else is in uart_rx.

Verification (CLKS_PER_BIT=16, clk period 10 ns)
REQ-026 Byte 8'hA5 sent 8N1 -> exactly one data_ready pulse, data_out=8'hA5, busy low afterwards, no error pulses.
REQ-027 8'hA5 then 8'h3C with zero idle gap -> two data_ready pulses 160 cycles apart, carrying 8'hA5 then 8'h3C.
REQ-028 rx low for 3 cycles, then high -> FSM returns to IDLE, no pulses, data_out unchanged.
REQ-029 8'h3C with the stop bit forced low -> frame_err pulse, data_out keeps its previous value; rx then held low -> no further activity until rx rises.
REQ-030 reset asserted during bit 4 of a frame, then 8'h5A sent -> all outputs 0 during reset, then data_ready with data_out=8'h5A.
REQ-031 With UART_RX_PARITY_EN: 8'hA5 with parity bit 1 (wrong) -> parity_err pulse, no data_ready; the same byte with parity bit 0 -> data_ready with data_out=8'hA5.
